// File: rtl/dot_matrix_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dot_matrix_scheduler
// Purpose  : Double-buffered 16x8 frame controller with two-source arbitration,
//            tear-free swap at scan-frame boundary, row scan and column blink.
// Revision : 1.0
// ============================================================================
module dot_matrix_scheduler #(
    parameter int BLINK_HALF = 5000
) (
    input  logic       clk_10000Hz,
    input  logic       reset,
    input  logic       i_src0_req,
    input  logic       i_src0_valid,
    input  logic [2:0] i_src0_row,
    input  logic [7:0] i_src0_left,
    input  logic [7:0] i_src0_right,
    input  logic       i_src0_last,
    output logic       o_src0_gnt,
    output logic       o_src0_done,
    input  logic       i_src1_req,
    input  logic       i_src1_valid,
    input  logic [2:0] i_src1_row,
    input  logic [7:0] i_src1_left,
    input  logic [7:0] i_src1_right,
    input  logic       i_src1_last,
    output logic       o_src1_gnt,
    output logic       o_src1_done,
    input  logic       i_blink_en,
    output logic [7:0] o_dot_row,
    output logic [7:0] o_dot_col_left,
    output logic [7:0] o_dot_col_right
);

    localparam int                 c_CNT_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_HALF - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_GNT0 = 2'd1;
    localparam logic [1:0] c_GNT1 = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_done0;
    logic               r_done1;
    logic               r_pending;
    logic [15:0]        r_front [8];
    logic [15:0]        r_back  [8];
    logic [2:0]         r_scan_row;
    logic [7:0]         r_dot_row;
    logic [7:0]         r_col_left;
    logic [7:0]         r_col_right;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_phase;

    logic               w_wr_en;
    logic [2:0]         w_wr_row;
    logic [15:0]        w_wr_data;
    logic               w_done0;
    logic               w_done1;
    logic               w_swap;
    logic               w_blank;

    // Arbiter state register; grants are registered from the next state
    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt0  <= (w_state_nxt == c_GNT0);
            r_gnt1  <= (w_state_nxt == c_GNT1);
            r_done0 <= w_done0;
            r_done1 <= w_done1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!r_pending) begin
                    if (i_src0_req)      w_state_nxt = c_GNT0;
                    else if (i_src1_req) w_state_nxt = c_GNT1;
                end
            end
            c_GNT0: if ((i_src0_valid & i_src0_last) | !i_src0_req) w_state_nxt = c_IDLE;
            c_GNT1: if ((i_src1_valid & i_src1_last) | !i_src1_req) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_row  = 3'd0;
        w_wr_data = 16'h0000;
        w_done0   = 1'b0;
        w_done1   = 1'b0;
        case (r_state)
            c_GNT0: begin
                w_wr_en   = i_src0_valid;
                w_wr_row  = i_src0_row;
                w_wr_data = {i_src0_left, i_src0_right};
                w_done0   = i_src0_valid & i_src0_last;
            end
            c_GNT1: begin
                w_wr_en   = i_src1_valid;
                w_wr_row  = i_src1_row;
                w_wr_data = {i_src1_left, i_src1_right};
                w_done1   = i_src1_valid & i_src1_last;
            end
            default: ;
        endcase
    end

    // Swap only while the last row is being shown so a frame never tears
    assign w_swap  = (r_scan_row == 3'd7) & r_pending;
    assign w_blank = i_blink_en & ~r_phase;

    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_front[i] <= 16'h0000;
                r_back[i]  <= 16'h0000;
            end
        end else begin
            if (w_wr_en) r_back[w_wr_row] <= w_wr_data;
            if (w_swap) begin
                for (int i = 0; i < 8; i++) r_front[i] <= r_back[i];
                r_pending <= 1'b0;
            end else if (w_done0 | w_done1) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            r_scan_row  <= 3'd0;
            r_dot_row   <= 8'hFF;
            r_col_left  <= 8'h00;
            r_col_right <= 8'h00;
        end else begin
            r_scan_row                 <= r_scan_row + 3'd1;
            r_dot_row                  <= ~(8'h80 >> r_scan_row);
            {r_col_left, r_col_right}  <= w_blank ? 16'h0000 : r_front[r_scan_row];
        end
    end

    always_ff @(posedge clk_10000Hz or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!i_blink_en) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == c_CNT_MAX) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_CNT_W'(1);
        end
    end

    assign o_src0_gnt      = r_gnt0;
    assign o_src1_gnt      = r_gnt1;
    assign o_src0_done     = r_done0;
    assign o_src1_done     = r_done1;
    assign o_dot_row       = r_dot_row;
    assign o_dot_col_left  = r_col_left;
    assign o_dot_col_right = r_col_right;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_matrix_scheduler
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_dot_matrix_scheduler;

    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   [2];
    logic       valid [2];
    logic [2:0] row   [2];
    logic [7:0] left  [2];
    logic [7:0] right [2];
    logic       last  [2];
    logic       blink_en;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] dot_row;
    logic [7:0] col_l;
    logic [7:0] col_r;

    int nerr = 0;
    int nchk = 0;

    // Reference model state
    int          m_owner;
    bit          m_pend;
    logic [15:0] m_front [8];
    logic [15:0] m_back  [8];
    int          m_edges;
    int          m_run;
    bit   [1:0]  e_g;
    bit   [1:0]  e_d;
    logic [7:0]  e_row;
    logic [7:0]  e_l;
    logic [7:0]  e_r;

    typedef struct {
        bit         req;
        bit         val;
        bit [2:0]   row;
        bit         last;
        bit         g;
        bit         d;
        logic [7:0] drow;
    } vec_t;

    vec_t tbl [10];

    dot_matrix_scheduler #(.BLINK_HALF(BH)) dut (
        .clk_10000Hz     (clk),
        .reset           (rst_n),
        .i_src0_req      (req[0]),
        .i_src0_valid    (valid[0]),
        .i_src0_row      (row[0]),
        .i_src0_left     (left[0]),
        .i_src0_right    (right[0]),
        .i_src0_last     (last[0]),
        .o_src0_gnt      (gnt[0]),
        .o_src0_done     (done[0]),
        .i_src1_req      (req[1]),
        .i_src1_valid    (valid[1]),
        .i_src1_row      (row[1]),
        .i_src1_left     (left[1]),
        .i_src1_right    (right[1]),
        .i_src1_last     (last[1]),
        .o_src1_gnt      (gnt[1]),
        .o_src1_done     (done[1]),
        .i_blink_en      (blink_en),
        .o_dot_row       (dot_row),
        .o_dot_col_left  (col_l),
        .o_dot_col_right (col_r)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_pend  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_front[i] = 16'h0;
            m_back[i]  = 16'h0;
        end
        m_edges = 0;
        m_run   = 0;
        e_g     = 2'b00;
        e_d     = 2'b00;
        e_row   = 8'hFF;
        e_l     = 8'h00;
        e_r     = 8'h00;
    endtask

    // One clock edge of the display/arbitration rules
    task automatic model_step();
        int         s;
        logic [7:0] oh;
        bit         vis;
        bit         swap;
        bit         npend;
        int         k;
        s     = m_edges % 8;
        oh    = 8'h80 >> s;
        e_row = ~oh;
        vis   = !blink_en || (((m_run / BH) % 2) == 0);
        e_l   = vis ? m_front[s][15:8] : 8'h00;
        e_r   = vis ? m_front[s][7:0]  : 8'h00;
        swap  = (s == 7) && m_pend;
        if (swap) m_front = m_back;
        npend = swap ? 1'b0 : m_pend;
        e_d   = 2'b00;
        if (m_owner < 0) begin
            if (!m_pend) begin
                if (req[0])      m_owner = 0;
                else if (req[1]) m_owner = 1;
            end
        end else begin
            k = m_owner;
            if (valid[k]) m_back[row[k]] = {left[k], right[k]};
            if (valid[k] && last[k]) begin
                m_owner = -1;
                e_d[k]  = 1'b1;
                npend   = 1'b1;
            end else if (!req[k]) begin
                m_owner = -1;
            end
        end
        m_pend  = npend;
        e_g     = {m_owner == 1, m_owner == 0};
        m_run   = blink_en ? m_run + 1 : 0;
        m_edges = m_edges + 1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic check_all();
        logic [27:0] got;
        logic [27:0] exp;
        got = {gnt, done, dot_row, col_l, col_r};
        exp = {e_g, e_d, e_row, e_l, e_r};
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL model t=%0t: got %h expected %h", $time, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_gnt(input int src, input int bound);
        int k;
        k = 0;
        while (!gnt[src] && k < bound) begin
            cyc();
            k++;
        end
        chk("gnt_wait", 32'(gnt[src]), 32'd1);
    endtask

    task automatic send_frame(input int src, input logic [7:0] lb, input logic [7:0] rb,
                              input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            valid[src] = 1'b1;
            row[src]   = 3'(i);
            left[src]  = lb + 8'(i);
            right[src] = rb ^ 8'(i);
            last[src]  = with_last && (i == n - 1);
            cyc();
        end
        valid[src] = 1'b0;
        last[src]  = 1'b0;
    endtask

    task automatic check_display(input string name, input logic [7:0] lb, input logic [7:0] rb,
                                 input bit blank);
        int          s;
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            cyc();
            s   = (m_edges - 1) % 8;
            exp = blank ? 16'h0 : {lb + 8'(s), rb ^ 8'(s)};
            chk(name, {16'h0, col_l, col_r}, {16'h0, exp});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] seen;

        tbl[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'h7F};
        tbl[1] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'hBF};
        tbl[2] = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'hDF};
        tbl[3] = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'hEF};
        tbl[4] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'hF7};
        tbl[5] = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'hFB};
        tbl[6] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'hFD};
        tbl[7] = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 8'hFE};
        tbl[8] = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'h7F};
        tbl[9] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'hBF};

        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; valid[s] = 1'b0; row[s] = 3'd0;
            left[s] = 8'h00; right[s] = 8'h00; last[s] = 1'b0;
        end
        blink_en = 1'b0;
        model_reset();

        // Reset holds outputs idle
        repeat (3) cyc();
        chk("reset_row", 32'(dot_row), 32'hFF);
        chk("reset_cols", {16'h0, col_l, col_r}, 32'h0);

        // Single frame from source 0, one vector per clock
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req[0]   = tbl[i].req;
            valid[0] = tbl[i].val;
            row[0]   = tbl[i].row;
            last[0]  = tbl[i].last;
            left[0]  = 8'h3C;
            right[0] = 8'h81;
            cyc();
            chk("tbl_gnt0",  32'(gnt[0]),  32'(tbl[i].g));
            chk("tbl_done0", 32'(done[0]), 32'(tbl[i].d));
            chk("tbl_row",   32'(dot_row), 32'(tbl[i].drow));
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("no_tear", {16'h0, col_l, col_r}, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("frame_a", {16'h0, col_l, col_r}, 32'h3C81);
        end

        // Simultaneous requests: source 0 first, source 1 after the swap
        req[0] = 1'b1;
        req[1] = 1'b1;
        cyc();
        chk("simul_first", 32'(gnt), 32'b01);
        send_frame(0, 8'h20, 8'h40, 8, 1'b1);
        chk("simul_done0", 32'(done[0]), 32'd1);
        chk("simul_g1_wait", 32'(gnt[1]), 32'd0);
        req[0] = 1'b0;
        wait_gnt(1, 20);
        send_frame(1, 8'h50, 8'h0F, 8, 1'b1);
        chk("simul_done1", 32'(done[1]), 32'd1);
        req[1] = 1'b0;
        repeat (12) cyc();
        check_display("frame_b", 8'h50, 8'h0F, 1'b0);

        // Aborted transfer leaves the display alone
        req[1] = 1'b1;
        wait_gnt(1, 20);
        send_frame(1, 8'hA0, 8'hA0, 3, 1'b0);
        req[1] = 1'b0;
        cyc();
        chk("abort_nodone", 32'(done[1]), 32'd0);
        chk("abort_gnt", 32'(gnt[1]), 32'd0);
        repeat (8) cyc();
        check_display("abort_keep", 8'h50, 8'h0F, 1'b0);
        req[0] = 1'b1;
        wait_gnt(0, 20);
        send_frame(0, 8'h10, 8'hC3, 8, 1'b1);
        req[0] = 1'b0;
        repeat (12) cyc();
        check_display("frame_c", 8'h10, 8'hC3, 1'b0);

        // Blink: 4 cycles data, 4 cycles blank
        blink_en = 1'b1;
        seen = 16'h0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            seen[15-i] = (col_l != 8'h00);
        end
        chk("blink_pattern", {16'h0, seen}, 32'hF0F0);
        repeat (4) cyc();
        cyc();
        chk("blink_off", 32'(col_l), 32'h0);
        blink_en = 1'b0;
        cyc();
        chk("blink_restore", 32'(col_l != 8'h00), 32'd1);

        // Reset in the middle of a transfer
        req[0] = 1'b1;
        wait_gnt(0, 20);
        send_frame(0, 8'h77, 8'h77, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt0", 32'(gnt[0]), 32'd0);
        chk("rst_done0", 32'(done[0]), 32'd0);
        chk("rst_row", 32'(dot_row), 32'hFF);
        model_reset();
        req[0] = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        check_display("post_rst_blank", 8'h00, 8'h00, 1'b1);
        check_display("post_rst_blank", 8'h00, 8'h00, 1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < 2; s++) begin
                valid[s] = 1'b0;
                last[s]  = 1'b0;
                if (e_d[s]) req[s] = 1'b0;
                if (e_g[s]) begin
                    if ($urandom_range(0, 39) == 0) begin
                        req[s] = 1'b0;
                    end else if ($urandom_range(0, 3) != 0) begin
                        valid[s] = 1'b1;
                        row[s]   = 3'($urandom);
                        left[s]  = 8'($urandom);
                        right[s] = 8'($urandom);
                        last[s]  = ($urandom_range(0, 7) == 0);
                    end
                end else begin
                    if (!req[s] && $urandom_range(0, 7) == 0) req[s] = 1'b1;
                    valid[s] = ($urandom_range(0, 3) == 0);
                    last[s]  = 1'($urandom);
                    row[s]   = 3'($urandom);
                    left[s]  = 8'($urandom);
                    right[s] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dot_matrix_scheduler.md
# dot_matrix_scheduler

Double-buffered frame controller for the dual 8x8 dot-matrix display, driven at 10 kHz. It arbitrates between two pattern sources: source 0 is game-state graphics and source 1 is animation/message graphics. The granted source writes a full 16x8 frame into a back buffer. The block swaps that buffer into the front buffer only at a scan-frame boundary, and it drives the shared active-low row lines and the left/right column lines. It replaces per-pattern hard-coding in the top level: producers only supply bitmaps.

## Interface
Parameters:
- BLINK_HALF, default 5000: cycles per blink half-period (0.5 s at 10 kHz).

Ports:
- clk_10000Hz  in  1  display/scan clock.
- reset  in  1  asynchronous, active-low.
- srcN_req  in  1  (N=0,1) request to write a frame; held high for the whole transfer.
- srcN_valid  in  1  row write strobe, honoured only while srcN_gnt=1.
- srcN_row  in  3  row index of the write (0 = top).
- srcN_left  in  8  left-panel columns for the row (1 = LED on).
- srcN_right  in  8  right-panel columns for the row.
- srcN_last  in  1  marks the final row write of the frame; qualified by srcN_valid.
- srcN_gnt  out  1  grant; source N owns the back buffer.
- srcN_done  out  1  one-cycle pulse: frame accepted.
- blink_en  in  1  1 = blank the columns during the off half-period.
- dot_row  out  8  active-low row select. Row r drives bit (7-r) low, so row 0 = 8'b01111111 and row 7 = 8'b11111110.
- dot_col_left  out  8  left column data.
- dot_col_right  out  8  right column data.

## Operation
- Storage: front[0..7] and back[0..7], each 16 bits ({left,right}), plus a pending flag.
- Arbiter FSM, states IDLE, GNT0, GNT1:
  - IDLE → GNT0 if src0_req & !pending.
  - Otherwise IDLE → GNT1 if src1_req & !pending. Fixed priority: source 0 wins a simultaneous request.
  - srcN_gnt is registered and equals (state==GNTN).
  - In GNTN, each cycle with srcN_valid=1 writes back[srcN_row] <= {srcN_left, srcN_right}. Repeated or out-of-order rows are allowed; the last write wins.
  - In GNTN, srcN_valid & srcN_last: perform the write, go to IDLE, set pending=1, pulse srcN_done for one cycle.
  - In GNTN, srcN_req low without last: abort. Go to IDLE, no done pulse, pending unchanged. The partial rows stay in back and are overwritten by the next transfer.
  - No preemption. A src0 request during GNT1 waits for GNT1 to end.
  - The non-granted source's valid/last are ignored.
- Scanner: 3-bit scan_row increments every cycle and wraps 7→0.
  - Each edge: dot_row <= row code for scan_row; columns <= front[scan_row], or 0 if blanked.
- Swap: on the edge where scan_row==7 and pending==1, front <= back (all 8 rows) and pending <= 0. Frames never tear.
- Blink:
  - blink_cnt counts 0..BLINK_HALF-1 and wraps; phase toggles on the wrap.
  - blink_en=0 forces phase=1 (visible) and clears blink_cnt.
  - blink_en=1 & phase=0: columns output 0 while dot_row keeps scanning.
- Reset (async, active-low) clears everything:
  - Outputs: dot_row=8'hFF, cols=0, gnt=0, done=0.
  - Internal: scan_row=0, state=IDLE, pending=0, front=back=0, blink_cnt=0, phase=1.
  - Reset mid-transfer discards the transfer with no done pulse.

## Timing
- Grant latency: src_req seen high at edge E (with !pending) gives gnt high after E. The first valid write is accepted at edge E+1.
- Throughput: one row per cycle, so a full frame takes 8 cycles under grant.
- done is high for the cycle after the last write edge; gnt drops in that same cycle.
- Back-to-back transfers: pending blocks a new grant until the swap, at most 8 cycles later. A source holding req is granted on the edge after pending clears.
- Display latency:
  - Swap occurs at the first scan_row==7 edge after pending is set.
  - New row 0 appears on the outputs at that swap edge +1 (outputs for scan_row lag one edge).
  - Worst case from last write to row 0 of the new frame is 9 cycles.
- After reset release, first edge: dot_row=8'b01111111, cols=front[0]=0.
- Frame rate: 1250 Hz. Blink: 1 Hz square wave (toggles every BLINK_HALF cycles).

## Test plan
- Reset/scan:
  - Stimulus: hold reset low, then release.
  - Response: dot_row=8'hFF and cols=0 during reset. After release, dot_row cycles 01111111, 10111111, … 11111110 and repeats every 8 cycles with cols=0.
- Single frame load:
  - Stimulus: src0 writes rows 0..7 with left=8'h3C and right=8'h81, last on row 7.
  - Response: gnt0 after 1 cycle, one done0 pulse, then every row displays left=8'h3C and right=8'h81 from the next scan row 0 onward. No partially updated frame is ever shown.
- Simultaneous requests:
  - Stimulus: src0_req and src1_req rise on the same edge.
  - Response: gnt0 first. gnt1 is asserted only after done0 and the swap. The final display equals src1's frame.
- Abort:
  - Stimulus: src1 writes 3 rows, then drops req.
  - Response: no done1 and no swap; the display is unchanged. A subsequent full src0 frame displays correctly.
- Blink (BLINK_HALF=4 in bench):
  - Stimulus: blink_en=1 with a non-zero frame loaded.
  - Response: cols alternate between 4 cycles of data and 4 cycles of zero, while dot_row scanning continues. blink_en=0 restores constant data immediately.
- Reset mid-transfer:
  - Stimulus: assert reset after src0 has written 4 rows.
  - Response: gnt0=0, no done0, front=0, and a blank display after release.
